scene_mixer: RTL and testbench
==============================

Name: scene_mixer

Overview:
Parametrised pixel compositor and per-frame collision detector for the VGA game datapath. It sits between the sprite/platform renderers and the VGA pins. It replaces the single-sprite colour gating with N prioritised layers and a background colour. It also publishes frame-latched collision flags between the player layer and every other layer, and applies an optional frame-periodic flash (colour inversion) effect.

Parameters:
NUM_LAYERS, 4, number of sprite layers; layer 0 is the player and has the highest priority
CW, 4, bits per colour channel
BG_COLOR, 12'h000, background colour {B,G,R}, 3*CW bits wide
COLLIDE_MASK, 4'b1110, bit k=1 enables player-vs-layer-k collision detection; bit 0 is ignored
FLASH_PERIOD, 8, frames per flash half-period (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
valid  in  1  beam is inside the visible area
hs_in  in  1  horizontal sync from the beam generator
vs_in  in  1  vertical sync from the beam generator
frame_start  in  1  one-cycle pulse at the start of each frame
layer_color  in  NUM_LAYERS*3*CW  per-layer colour; layer k occupies bits [k*3*CW +: 3*CW], packed {B,G,R}
layer_opaque  in  NUM_LAYERS  per-layer pixel-present flag
flash_en  in  1  enables the flash effect
vga_r  out  CW  registered red
vga_g  out  CW  registered green
vga_b  out  CW  registered blue
hs_out  out  1  hs_in delayed 1 cycle
vs_out  out  1  vs_in delayed 1 cycle
collision_flags  out  NUM_LAYERS  latched collisions of the previous frame; bit 0 is always 0
collision_valid  out  1  one-cycle pulse when collision_flags update
flash_phase  out  1  current flash phase

Behaviour:
- Reset (rst=0, asynchronous): vga_r/g/b=0, hs_out=0, vs_out=0, collision_flags=0, collision_valid=0, flash_phase=0. The internal accumulator and frame counter are also cleared. Reset mid-frame discards any partial collision data.
- Colour select (combinational): take the lowest-index k with layer_opaque[k]=1 and use layer_color[k]. If no layer is opaque, use BG_COLOR.
- Flash: if flash_en=1 and flash_phase=1, every channel is bitwise inverted.
- Blanking: if valid=0, the pixel is forced to 0. Inversion is never applied while blanked.
- Output latency: exactly 1 cycle. vga_*, hs_out and vs_out are registered on the same edge, so sync and colour stay aligned.
- Collision hit (per cycle): hit[k] = valid & layer_opaque[0] & layer_opaque[k] & COLLIDE_MASK[k], for k>=1. hit[0]=0.
- Accumulator update: acc |= hit on every cycle.
- On frame_start=1:
  - collision_flags <= acc | hit; a hit in the same cycle belongs to the closing frame.
  - acc <= 0.
  - collision_valid=1 on the next cycle only.
- Back-to-back frame_start pulses are legal. The second pulse publishes only the hits seen between the two pulses.
- Flash counter: a frame counter of width clog2(FLASH_PERIOD), minimum 1 bit.
  - flash_en=1: the counter increments on each frame_start. At FLASH_PERIOD-1 it wraps to 0 and flash_phase toggles.
  - flash_en=0: counter=0 and flash_phase=0, applied synchronously. Re-enabling starts from phase 0.
  - FLASH_PERIOD=1: flash_phase toggles on every frame_start.

Decomposition:
- Package scene_pkg holds:
  - typedef rgb_t, a packed struct {b,g,r} of CW bits each;
  - localparam RGB_W = 3*CW;
  - a function invert_rgb.
  CW is a package localparam shared with the renderers.
- One sub-module: layer_priority_mux, combinational. It is parametrised by NUM_LAYERS and outputs the selected rgb_t plus an any_opaque flag.
- Collision accumulation, the flash FSM and the output registers stay in the top of scene_mixer.

Test Plan:
- Reset priority: assert rst=0 during activity -> all outputs 0 immediately (asynchronous). After release with valid=1 and no layer opaque -> vga_* = BG_COLOR one cycle later.
- Layer priority: layer_opaque=4'b0110, layer1=12'h0F0, layer2=12'h00F -> vga_g=F, vga_r=0, vga_b=0 after 1 cycle. Drive valid=0 -> output 0.
- Collision latch: overlap layers 0 and 2 for 3 pixels mid-frame, then pulse frame_start -> collision_flags=4'b0100 and collision_valid high for exactly one cycle. Next frame with no overlap -> flags=0.
- Simultaneous hit and pulse: a hit on layer 1 only in the same cycle as frame_start -> flags=4'b0010. The following frame's flags do not include it.
- Mask: COLLIDE_MASK=4'b1010 with a layer-2 overlap -> flags=0.
- Flash: FLASH_PERIOD=2, flash_en=1, layer0=12'h123 -> flash_phase toggles every 2 frame_start pulses and output becomes 12'hEDC in phase 1. Drop flash_en -> phase=0 next cycle and output returns to 12'h123.

Source files
------------

// File: rtl/scene_pkg.sv
// Shared pixel types for the VGA game datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: CW (bits per colour channel), RGB_W, the rgb_t pixel struct and invert_rgb.
package scene_pkg;

  localparam int CW    = 4;
  localparam int RGB_W = 3 * CW;

  // Packed {B,G,R}, matching the renderers' colour bus layout.
  typedef struct packed {
    logic [CW-1:0] b;
    logic [CW-1:0] g;
    logic [CW-1:0] r;
  } rgb_t;

  function automatic rgb_t invert_rgb(input rgb_t c);
    rgb_t o;
    o.b = ~c.b;
    o.g = ~c.g;
    o.r = ~c.r;
    return o;
  endfunction

endpackage

// File: rtl/layer_priority_mux.sv
// Picks the colour of the lowest-index opaque layer (layer 0 wins).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, one pixel per cycle.
// Ports: layer_color/layer_opaque in; sel_color (zero when nothing opaque), any_opaque out.
module layer_priority_mux
  import scene_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]       layer_opaque,
  output rgb_t                        sel_color,
  output logic                        any_opaque
);

  // Walk from the highest index down so the last hit, the lowest index, wins.
  always_comb begin
    sel_color = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_opaque[k]) begin
        sel_color = layer_color[k*RGB_W +: RGB_W];
      end
    end
  end

  assign any_opaque = |layer_opaque;

endmodule

// File: rtl/scene_mixer.sv
// Layer compositor with frame-latched player collisions and a frame-periodic flash.
// Latency: 1 cycle from inputs to vga_*/hs_out/vs_out; collision_flags 1 cycle after frame_start.
// Backpressure: none, follows the pixel clock every cycle.
// Ports: clk, rst (async active-low), beam valid/hs_in/vs_in/frame_start, layer_color/opaque,
//        flash_en -> vga_r/g/b, hs_out, vs_out, collision_flags, collision_valid, flash_phase.
module scene_mixer
  import scene_pkg::*;
#(
  parameter int                    NUM_LAYERS   = 4,
  parameter logic [RGB_W-1:0]      BG_COLOR     = 12'h000,
  parameter logic [NUM_LAYERS-1:0] COLLIDE_MASK = 4'b1110,
  parameter int                    FLASH_PERIOD = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic                        hs_in,
  input  logic                        vs_in,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]       layer_opaque,
  input  logic                        flash_en,
  output logic [CW-1:0]               vga_r,
  output logic [CW-1:0]               vga_g,
  output logic [CW-1:0]               vga_b,
  output logic                        hs_out,
  output logic                        vs_out,
  output logic [NUM_LAYERS-1:0]       collision_flags,
  output logic                        collision_valid,
  output logic                        flash_phase
);

  localparam int CNT_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_PERIOD - 1);
  // The player never collides with itself.
  localparam logic [NUM_LAYERS-1:0] HIT_MASK = COLLIDE_MASK & ~(NUM_LAYERS'(1));

  rgb_t                  sel_color;
  logic                  any_opaque;
  rgb_t                  pix;
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] acc;
  logic [CNT_W-1:0]      frame_cnt;

  layer_priority_mux #(.NUM_LAYERS(NUM_LAYERS)) u_mux (
    .layer_color  (layer_color),
    .layer_opaque (layer_opaque),
    .sel_color    (sel_color),
    .any_opaque   (any_opaque)
  );

  // Blanking takes precedence over inversion so the porch stays black.
  always_comb begin
    pix = any_opaque ? sel_color : rgb_t'(BG_COLOR);
    if (flash_en && flash_phase) begin
      pix = invert_rgb(pix);
    end
    if (!valid) begin
      pix = '0;
    end
  end

  assign hit = (valid && layer_opaque[0]) ? (layer_opaque & HIT_MASK) : '0;

  // Pixel and sync share one register stage so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else begin
      vga_r  <= pix.r;
      vga_g  <= pix.g;
      vga_b  <= pix.b;
      hs_out <= hs_in;
      vs_out <= vs_in;
    end
  end

  // A hit coinciding with frame_start is folded into the frame being closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc             <= '0;
      collision_flags <= '0;
      collision_valid <= 1'b0;
    end else if (frame_start) begin
      collision_flags <= acc | hit;
      acc             <= '0;
      collision_valid <= 1'b1;
    end else begin
      acc             <= acc | hit;
      collision_valid <= 1'b0;
    end
  end

  // Flash frame counter; disabling parks it so re-enabling always starts in phase 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (!flash_en) begin
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_MAX) begin
        frame_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scene_mixer.sv
// Directed bench for scene_mixer: two instances share stimulus.
//   dut_a: BG_COLOR=12'h5A3, COLLIDE_MASK=4'b1110, FLASH_PERIOD=2
//   dut_b: BG_COLOR=12'h000, COLLIDE_MASK=4'b1010, FLASH_PERIOD=8
module tb_scene_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        hs_in;
  logic        vs_in;
  logic        frame_start;
  logic [47:0] layer_color;
  logic [3:0]  layer_opaque;
  logic        flash_en;

  logic [3:0] a_r, a_g, a_b, a_flags;
  logic       a_hs, a_vs, a_cv, a_ph;
  logic [3:0] b_r, b_g, b_b, b_flags;
  logic       b_hs, b_vs, b_cv, b_ph;

  logic [11:0] a_pix, b_pix;
  assign a_pix = {a_b, a_g, a_r};
  assign b_pix = {b_b, b_g, b_r};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scene_mixer #(.BG_COLOR(12'h5A3), .COLLIDE_MASK(4'b1110), .FLASH_PERIOD(2)) dut_a (
    .clk(clk), .rst(rst), .valid(valid), .hs_in(hs_in), .vs_in(vs_in),
    .frame_start(frame_start), .layer_color(layer_color), .layer_opaque(layer_opaque),
    .flash_en(flash_en), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .hs_out(a_hs),
    .vs_out(a_vs), .collision_flags(a_flags), .collision_valid(a_cv), .flash_phase(a_ph)
  );

  scene_mixer #(.BG_COLOR(12'h000), .COLLIDE_MASK(4'b1010), .FLASH_PERIOD(8)) dut_b (
    .clk(clk), .rst(rst), .valid(valid), .hs_in(hs_in), .vs_in(vs_in),
    .frame_start(frame_start), .layer_color(layer_color), .layer_opaque(layer_opaque),
    .flash_en(flash_en), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hs_out(b_hs),
    .vs_out(b_vs), .collision_flags(b_flags), .collision_valid(b_cv), .flash_phase(b_ph)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; hs_in = 1'b0; vs_in = 1'b0; frame_start = 1'b0;
    layer_color = '0; layer_opaque = '0; flash_en = 1'b0;
    #3;
    chk("rst_a_pix", 32'(a_pix), 32'h000);
    chk("rst_a_flags", 32'(a_flags), 32'h0);
    chk("rst_a_cv", 32'(a_cv), 32'h0);
    chk("rst_a_ph", 32'(a_ph), 32'h0);
    chk("rst_a_sync", 32'({a_hs, a_vs}), 32'h0);
    rst = 1'b1;

    // Background after reset release; sync delayed by one cycle.
    valid = 1'b1; hs_in = 1'b1;
    cyc();
    chk("bg_a", 32'(a_pix), 32'h5A3);
    chk("bg_b", 32'(b_pix), 32'h000);
    chk("hs_out", 32'(a_hs), 32'h1);
    chk("vs_out_lo", 32'(a_vs), 32'h0);

    // Priority: layer 1 beats layer 2.
    layer_color = {12'h000, 12'h00F, 12'h0F0, 12'h000};
    layer_opaque = 4'b0110; hs_in = 1'b0; vs_in = 1'b1;
    cyc();
    chk("prio_a", 32'(a_pix), 32'h0F0);
    chk("prio_b", 32'(b_pix), 32'h0F0);
    chk("vs_out_hi", 32'(a_vs), 32'h1);
    valid = 1'b0;
    cyc();
    chk("blank_a", 32'(a_pix), 32'h000);

    // Asynchronous reset during activity.
    valid = 1'b1; vs_in = 1'b0; hs_in = 1'b1;
    layer_color = {12'h000, 12'h00F, 12'h0F0, 12'h123};
    layer_opaque = 4'b0001;
    cyc();
    chk("l0_a", 32'(a_pix), 32'h123);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pix", 32'(a_pix), 32'h000);
    chk("async_rst_hs", 32'(a_hs), 32'h0);
    rst = 1'b1;

    // Collision latch: layers 0 and 2 overlap for 3 pixels.
    layer_opaque = 4'b0101;
    cyc(); cyc(); cyc();
    layer_opaque = 4'b0000; frame_start = 1'b1;
    cyc();
    chk("coll_a_flags", 32'(a_flags), 32'h4);
    chk("coll_a_cv", 32'(a_cv), 32'h1);
    chk("mask_b_flags", 32'(b_flags), 32'h0);
    chk("coll_b_cv", 32'(b_cv), 32'h1);
    frame_start = 1'b0;
    cyc();
    chk("coll_cv_drop", 32'(a_cv), 32'h0);
    chk("coll_hold", 32'(a_flags), 32'h4);
    // Layer-3 overlap, enabled on both masks.
    layer_opaque = 4'b1001;
    cyc();
    layer_opaque = 4'b0000;
    cyc();
    frame_start = 1'b1;
    cyc();
    chk("l3_a_flags", 32'(a_flags), 32'h8);
    chk("l3_b_flags", 32'(b_flags), 32'h8);
    // Next frame, no overlap.
    frame_start = 1'b0;
    cyc(); cyc();
    frame_start = 1'b1;
    cyc();
    chk("noov_a_flags", 32'(a_flags), 32'h0);

    // Hit on layer 1 in the frame_start cycle, then a back-to-back pulse.
    layer_opaque = 4'b0011;
    cyc();
    chk("same_a_flags", 32'(a_flags), 32'h2);
    chk("same_b_flags", 32'(b_flags), 32'h2);
    layer_opaque = 4'b0000;
    cyc();
    chk("b2b_a_flags", 32'(a_flags), 32'h0);
    chk("b2b_a_cv", 32'(a_cv), 32'h1);
    // Overlap while blanked never counts.
    frame_start = 1'b0; valid = 1'b0; layer_opaque = 4'b0011;
    cyc();
    valid = 1'b1; layer_opaque = 4'b0000; frame_start = 1'b1;
    cyc();
    chk("blank_hit_a", 32'(a_flags), 32'h0);

    // Flash, FLASH_PERIOD=2 on dut_a.
    frame_start = 1'b0; flash_en = 1'b1; layer_opaque = 4'b0001;
    cyc();
    frame_start = 1'b1;
    cyc();                                        // pulse 1
    chk("fl_p1_ph", 32'(a_ph), 32'h0);
    cyc();                                        // pulse 2
    chk("fl_p2_ph", 32'(a_ph), 32'h1);
    chk("fl_p2_pix", 32'(a_pix), 32'h123);
    frame_start = 1'b0;
    cyc();
    chk("fl_inv_a", 32'(a_pix), 32'hEDC);
    chk("fl_inv_b", 32'(b_pix), 32'h123);
    valid = 1'b0;
    cyc();
    chk("fl_blank", 32'(a_pix), 32'h000);
    valid = 1'b1; frame_start = 1'b1;
    cyc();                                        // pulse 3
    chk("fl_p3_ph", 32'(a_ph), 32'h1);
    cyc();                                        // pulse 4
    chk("fl_p4_ph", 32'(a_ph), 32'h0);
    cyc(); cyc();                                 // pulses 5, 6
    chk("fl_p6_ph", 32'(a_ph), 32'h1);
    chk("fl_b_ph", 32'(b_ph), 32'h0);
    frame_start = 1'b0; flash_en = 1'b0;
    cyc();
    chk("fl_off_ph", 32'(a_ph), 32'h0);
    chk("fl_off_pix", 32'(a_pix), 32'h123);
    // Re-enable restarts the count from zero.
    flash_en = 1'b1; frame_start = 1'b1;
    cyc();
    chk("fl_re_ph", 32'(a_ph), 32'h0);
    frame_start = 1'b0;
    cyc();
    chk("fl_re_pix", 32'(a_pix), 32'h123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
